// File: rtl/peakbin_detect_pkg.sv
// Shared types for the beamformer front end: sample layout,
// bus widths and the peak finder state encoding.
package peakbin_detect_pkg;

  localparam int FFT_W  = 28;
  localparam int HALF_W = 14;
  localparam int BIN_W  = 10;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cpx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    HOLD
  } state_t;

endpackage

// File: rtl/peakbin_detect_magsq.sv
// Registered |x|^2 of a complex sample, one cycle latency.
// Also used by the weight block's power stage.
module cpx_magsq
  import peakbin_detect_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  cpx_t             sample,
  output logic             pwr_valid,
  output logic [FFT_W-1:0] pwr
);

  logic signed [2*HALF_W-1:0] re2;
  logic signed [2*HALF_W-1:0] im2;

  // each square is non-negative and below 2^27, so the sum fits
  assign re2 = sample.re * sample.re;
  assign im2 = sample.im * sample.im;

  always_ff @(posedge clk) begin
    if (reset) pwr_valid <= 1'b0;
    else       pwr_valid <= valid;
  end

  always_ff @(posedge clk) begin
    pwr <= FFT_W'($unsigned(re2)) + FFT_W'($unsigned(im2));
  end

endmodule

// File: rtl/peakbin_detect.sv
// Scans FFT RAM 1 for the strongest bin, publishes it and
// parks the read address there until the weight block is done.
module peakbin_detect
  import peakbin_detect_pkg::*;
#(
  parameter int          NBINS  = 2**BIN_W,
  parameter int          BINLO  = 1,
  parameter int          BINHI  = 511,
  parameter int          RDLAT  = 2,
  parameter int unsigned THRESH = 0,
  localparam int         AW     = $clog2(NBINS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fftdone,
  input  logic [FFT_W-1:0] ramq1,
  input  logic             wbdone,
  output logic [AW-1:0]    rdaddr1,
  output logic [AW-1:0]    maxbin,
  output logic [FFT_W-1:0] maxpwr,
  output logic             detectdone,
  output logic             nodetect,
  output logic             overrun
);

  localparam logic [AW-1:0]    LO = AW'(BINLO);
  localparam logic [AW-1:0]    HI = AW'(BINHI);
  localparam logic [FFT_W-1:0] TH = FFT_W'(THRESH);

  state_t            state;
  logic [RDLAT-1:0]  vsr;
  logic [AW-1:0]     binsr [RDLAT];
  logic [AW-1:0]     pbin;
  logic              pvld;
  logic [FFT_W-1:0]  pwr;
  logic [FFT_W-1:0]  runpwr;
  logic [AW-1:0]     runbin;
  logic              hit;
  logic [FFT_W-1:0]  nxt_pwr;
  logic [AW-1:0]     nxt_bin;
  logic [FFT_W:0]    diff;
  logic              below;

  always_ff @(posedge clk) begin
    if (reset) begin
      vsr <= '0;
    end else begin
      vsr[0] <= (state == SCAN);
      for (int i = 1; i < RDLAT; i++) vsr[i] <= vsr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    binsr[0] <= rdaddr1;
    for (int i = 1; i < RDLAT; i++) binsr[i] <= binsr[i-1];
    pbin <= binsr[RDLAT-1];
  end

  cpx_magsq u_magsq (
    .clk       (clk),
    .reset     (reset),
    .valid     (vsr[RDLAT-1]),
    .sample    (cpx_t'(ramq1)),
    .pwr_valid (pvld),
    .pwr       (pwr)
  );

  // strict compare: equal powers keep the earlier (lower) bin
  assign hit     = pvld && (pwr > runpwr);
  assign nxt_pwr = hit ? pwr : runpwr;
  assign nxt_bin = hit ? pbin : runbin;
  assign diff    = {1'b0, nxt_pwr} - {1'b0, TH};
  assign below   = diff[FFT_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rdaddr1    <= '0;
      maxbin     <= '0;
      maxpwr     <= '0;
      detectdone <= 1'b0;
      nodetect   <= 1'b0;
      overrun    <= 1'b0;
      runpwr     <= '0;
      runbin     <= '0;
    end else begin
      detectdone <= 1'b0;
      nodetect   <= 1'b0;
      runpwr     <= nxt_pwr;
      runbin     <= nxt_bin;
      if (fftdone && state != IDLE) overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (fftdone) begin
            rdaddr1 <= LO;
            runpwr  <= '0;
            runbin  <= LO;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (rdaddr1 == HI) state <= DRAIN;
          else rdaddr1 <= rdaddr1 + AW'(1);
        end
        DRAIN: begin
          // last sample is being compared when nothing is left upstream
          if (vsr == '0) begin
            if (!below) begin
              maxbin     <= nxt_bin;
              maxpwr     <= nxt_pwr;
              rdaddr1    <= nxt_bin;
              detectdone <= 1'b1;
              state      <= HOLD;
            end else begin
              nodetect <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        HOLD: begin
          if (wbdone) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peakbin_detect.sv
// Directed bench for peakbin_detect with a frame-level model.
module tb_peakbin_detect;

  localparam int LO = 1;
  localparam int HI = 511;
  localparam int RDLAT = 2;
  localparam int TH = 1000;

  logic        clk = 0;
  logic        reset = 1;
  logic        fftdone = 0;
  logic        wbdone = 0;
  logic [27:0] ramq1;
  logic [9:0]  rdaddr1;
  logic [9:0]  maxbin;
  logic [27:0] maxpwr;
  logic        detectdone;
  logic        nodetect;
  logic        overrun;

  logic [27:0] mem [1024];
  logic [27:0] q1;

  int npass = 0;
  int ntot = 0;
  bit en = 0;

  always #5 clk = ~clk;

  peakbin_detect #(
    .BINLO (LO),
    .BINHI (HI),
    .RDLAT (RDLAT),
    .THRESH(TH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fftdone   (fftdone),
    .ramq1     (ramq1),
    .wbdone    (wbdone),
    .rdaddr1   (rdaddr1),
    .maxbin    (maxbin),
    .maxpwr    (maxpwr),
    .detectdone(detectdone),
    .nodetect  (nodetect),
    .overrun   (overrun)
  );

  // two-register RAM read path: address to data in RDLAT=2 cycles
  always @(posedge clk) begin
    q1    <= mem[rdaddr1];
    ramq1 <= q1;
  end

  task automatic chk(string name, longint act, longint exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
  endtask

  // frame-level model: cycle count since fftdone, peak from the array
  int     mode = 0;
  int     t = 0;
  int     pk_bin;
  longint pk_pwr;
  int     e_rd = 0, e_bin = 0;
  longint e_pwr = 0;
  bit     e_dd = 0, e_nd = 0, e_ov = 0;

  always @(posedge clk) begin
    logic signed [13:0] r, m;
    longint p;
    if (reset) begin
      mode = 0; e_rd = 0; e_bin = 0; e_pwr = 0;
      e_dd = 0; e_nd = 0; e_ov = 0;
    end else begin
      e_dd = 0;
      e_nd = 0;
      if (fftdone && mode != 0) e_ov = 1;
      case (mode)
        0: if (fftdone) begin
          mode = 1; t = 0; e_rd = LO;
          pk_bin = LO; pk_pwr = 0;
          for (int b = LO; b <= HI; b++) begin
            r = mem[b][27:14];
            m = mem[b][13:0];
            p = longint'(r) * r + longint'(m) * m;
            if (p > pk_pwr) begin pk_pwr = p; pk_bin = b; end
          end
        end
        1: begin
          t++;
          e_rd = (t <= HI - LO) ? LO + t : HI;
          if (t == (HI - LO + 1) + RDLAT + 1) begin
            if (pk_pwr >= TH) begin
              e_dd = 1; e_bin = pk_bin; e_pwr = pk_pwr;
              e_rd = pk_bin; mode = 2;
            end else begin
              e_nd = 1; mode = 0;
            end
          end
        end
        2: if (wbdone) mode = 0;
        default: mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("rdaddr1", rdaddr1, e_rd);
      chk("maxbin", maxbin, e_bin);
      chk("maxpwr", maxpwr, e_pwr);
      chk("detectdone", detectdone, e_dd);
      chk("nodetect", nodetect, e_nd);
      chk("overrun", overrun, e_ov);
    end
  end

  task automatic fill(int re, int im);
    for (int b = 0; b < 1024; b++) mem[b] = {14'(re), 14'(im)};
  endtask

  task automatic put(int b, int re, int im);
    mem[b] = {14'(re), 14'(im)};
  endtask

  task automatic pulse_fft();
    @(posedge clk); #1 fftdone = 1;
    @(posedge clk); #1 fftdone = 0;
  endtask

  task automatic pulse_wb();
    @(posedge clk); #1 wbdone = 1;
    @(posedge clk); #1 wbdone = 0;
  endtask

  task automatic wait_pulse(output int n, output bit dd, output bit nd);
    n = 0; dd = 0; nd = 0;
    while (n < 2000 && !dd && !nd) begin
      @(negedge clk);
      n++;
      dd = detectdone;
      nd = nodetect;
    end
  endtask

  int n;
  bit dd, nd, found;

  initial begin
    fill(0, 0);
    repeat (3) @(posedge clk);
    en = 1;
    #1 reset = 0;
    @(negedge clk);
    chk("rst_rdaddr1", rdaddr1, 0);
    chk("rst_maxpwr", maxpwr, 0);
    chk("rst_overrun", overrun, 0);

    // single tone
    fill(10, 10);
    put(100, 3000, -4000);
    pulse_fft();
    wait_pulse(n, dd, nd);
    chk("tone_detect", dd, 1);
    chk("tone_latency", n, 515);
    chk("tone_maxbin", maxbin, 100);
    chk("tone_maxpwr", maxpwr, 25000000);
    repeat (5) @(negedge clk);
    chk("tone_park", rdaddr1, 100);
    pulse_wb();

    // tie at extremes, DC bin excluded
    fill(0, 0);
    put(0, 8191, 0);
    put(5, -8192, -8192);
    put(400, -8192, -8192);
    pulse_fft();
    wait_pulse(n, dd, nd);
    chk("tie_detect", dd, 1);
    chk("tie_maxbin", maxbin, 5);
    chk("tie_maxpwr", maxpwr, 134217728);
    pulse_wb();

    // below threshold
    fill(10, 10);
    pulse_fft();
    wait_pulse(n, dd, nd);
    chk("thr_nodetect", nd, 1);
    chk("thr_no_dd", dd, 0);
    chk("thr_keep_bin", maxbin, 5);
    chk("thr_keep_pwr", maxpwr, 134217728);

    // overrun during scan and hold
    put(77, 100, 100);
    pulse_fft();
    repeat (50) @(posedge clk);
    pulse_fft();
    wait_pulse(n, dd, nd);
    chk("ovr_detect", dd, 1);
    chk("ovr_maxbin", maxbin, 77);
    pulse_fft();
    @(negedge clk);
    chk("ovr_flag", overrun, 1);
    pulse_wb();

    // back-to-back frames
    fill(10, 10);
    put(50, 500, 0);
    pulse_fft();
    wait_pulse(n, dd, nd);
    chk("a_maxbin", maxbin, 50);
    chk("a_maxpwr", maxpwr, 250000);
    pulse_wb();
    fill(10, 10);
    put(300, 0, -700);
    pulse_fft();
    wait_pulse(n, dd, nd);
    chk("b_maxbin", maxbin, 300);
    chk("b_maxpwr", maxpwr, 490000);
    @(posedge clk); #1 begin fftdone = 1; wbdone = 1; end
    @(posedge clk); #1 begin fftdone = 0; wbdone = 0; end
    repeat (3) @(negedge clk);

    // reset in the middle of a scan
    fill(10, 10);
    put(123, 2000, 2000);
    pulse_fft();
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (rdaddr1 == 200) found = 1;
    end
    chk("reach_bin200", found, 1);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("mid_rdaddr1", rdaddr1, 0);
    chk("mid_maxbin", maxbin, 0);
    chk("mid_overrun", overrun, 0);
    chk("mid_dd", detectdone, 0);
    repeat (600) @(posedge clk);
    pulse_fft();
    wait_pulse(n, dd, nd);
    chk("post_detect", dd, 1);
    chk("post_maxbin", maxbin, 123);
    chk("post_maxpwr", maxpwr, 8000000);
    pulse_wb();
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/peakbin_detect.md
Name: peakbin_detect

Overview:
- Spectral peak finder that runs ahead of the beamforming weight block.
- After the channel-1 FFT frame is written to FFT RAM 1, it scans a bin range and computes |X|^2 per bin, keeping the strongest bin.
- It publishes maxbin and pulses detectdone.
- It then parks rdaddr1 on maxbin so the weight block can read channel 1 at that bin. It releases rdaddr1 when the weight block reports done.

Parameters:
- NBINS, 1024, FFT length; sets the address width of 10.
- BINLO, 1, first bin scanned; skips DC.
- BINHI, 511, last bin scanned; positive-frequency half only.
- RDLAT, 2, FFT RAM read latency in cycles, from address to ramq1 valid.
- THRESH, 0, minimum peak power; a peak must satisfy power >= THRESH for detectdone to fire.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- fftdone  in  1  one-cycle pulse: FFT frame fully written to RAMs
- ramq1  in  28  FFT RAM 1 data; [27:14] signed real, [13:0] signed imag
- wbdone  in  1  one-cycle pulse from the weight block: DOA computed
- rdaddr1  out  10  FFT RAM 1 read address
- maxbin  out  10  bin of maximum power; shared address for the RAM 2-4 reads
- maxpwr  out  28  power at maxbin, unsigned
- detectdone  out  1  one-cycle pulse: maxbin/maxpwr valid
- nodetect  out  1  one-cycle pulse: scan done, peak below THRESH
- overrun  out  1  sticky flag: fftdone arrived while busy

Behaviour:
- Reset values: rdaddr1=0, maxbin=0, maxpwr=0, detectdone=0, nodetect=0, overrun=0. Internal state goes to IDLE; all pipeline valid bits are cleared.
- Reset mid-operation aborts the scan immediately. No pulse is emitted.
- Power arithmetic:
  - pwr = re*re + im*im, both operands sign-extended 14-bit.
  - Each square is 27 bits unsigned; the sum is 28 bits unsigned. It cannot overflow.
  - Most negative input: (-8192)^2*2 = 2^27, which fits in 28 bits.
- Pipeline:
  - One address is issued per cycle.
  - A valid shift register of depth RDLAT tags returning ramq1 samples with their bin.
  - A registered power stage adds one cycle, then the compare occurs.
  - Bin-to-compare latency is RDLAT+1.
- States:
  - IDLE: rdaddr1 holds its last value. On fftdone: rdaddr1<=BINLO, running max cleared (pwr 0, bin BINLO), go SCAN.
  - SCAN: rdaddr1 increments each cycle. After issuing BINHI, go DRAIN. rdaddr1 stays at BINHI.
  - DRAIN: wait until the pipeline valid bits are all zero. Total scan length is (BINHI-BINLO+1)+RDLAT+1 cycles from the SCAN entry.
    - If running max >= THRESH: register maxbin/maxpwr, assert detectdone for 1 cycle, rdaddr1<=running bin, go HOLD.
    - Otherwise: assert nodetect for 1 cycle, leave maxbin/maxpwr unchanged, go IDLE.
  - HOLD: rdaddr1 is held at maxbin. On wbdone, go IDLE.
- Compare is strict (pwr > runmax); ties keep the lowest bin. An all-zero frame yields maxbin=BINLO, maxpwr=0.
- maxbin and maxpwr are stable from detectdone until the next detectdone.
- fftdone in SCAN, DRAIN or HOLD is ignored and sets overrun. overrun clears only on reset.
- fftdone and wbdone together in HOLD: go IDLE; the fftdone is counted as an overrun.
- wbdone outside HOLD is ignored.
- detectdone and nodetect are never high simultaneously and never high for two consecutive cycles.

Decomposition:
- Shared package (beamformer pkg):
  - FFT_W=28, HALF_W=14, BIN_W=10.
  - Typedef for the complex sample split into re/im.
  - The state enum {IDLE, SCAN, DRAIN, HOLD}.
- Sub-module cpx_magsq: registered re^2+im^2, 1-cycle latency, 28-bit output.
  - It is reusable by the weight block's power stage.
- The FSM, address counter and running max stay in the top module.

Test Plan:
- Single tone: RAM model with bin 100 = (3000,-4000), all others (10,10); fftdone -> detectdone at cycle 511+2+1+1 after fftdone, maxbin=100, maxpwr=25000000, rdaddr1=100 until wbdone.
- Tie/extremes: bins 5 and 400 both (-8192,-8192), others 0 -> maxbin=5, maxpwr=134217728; bin 0 = (8191,0) is not selected because BINLO=1.
- Threshold: THRESH=1000, all bins (10,10) -> nodetect pulse, no detectdone, maxbin/maxpwr retain their previous frame values, state returns to IDLE.
- Overrun: second fftdone during SCAN and another during HOLD -> both ignored, overrun=1, exactly one detectdone; after wbdone a new fftdone starts a clean scan.
- Reset mid-scan: reset at bin 200 -> next cycle all outputs are at reset values and no pulse appears; a subsequent fftdone scans normally and detects correctly.
- Back-to-back frames: frame A peak at bin 50, wbdone, then frame B peak at bin 300 -> maxbin changes 50->300 only at B's detectdone; rdaddr1 follows BINLO..BINHI then 300.
